// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue sequencer: opcode encodings, instruction
// field positions, FSM states and writeback classification helpers.
package alu_issue_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 2;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_SHIFT  = 4'h4;
  localparam logic [3:0] OP_MOVE   = 4'h5;
  localparam logic [3:0] OP_LOADC  = 4'h6;
  localparam logic [3:0] OP_LOAD   = 4'h7;
  localparam logic [3:0] OP_STORE  = 4'h8;
  localparam logic [3:0] OP_JUMP   = 4'h9;
  localparam logic [3:0] OP_UNDEF1 = 4'hA;
  localparam logic [3:0] OP_UNDEF2 = 4'hB;
  localparam logic [3:0] OP_UNDEF3 = 4'hC;
  localparam logic [3:0] OP_UNDEF4 = 4'hD;
  localparam logic [3:0] OP_UNDEF5 = 4'hE;
  localparam logic [3:0] OP_UNDEF6 = 4'hF;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int EXT_HI   = 11;
  localparam int EXT_LO   = 10;
  localparam int RA_HI    = 9;
  localparam int RA_LO    = 8;
  localparam int RB_HI    = 7;
  localparam int RB_LO    = 6;
  localparam int CONST_HI = 7;
  localparam int CONST_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic op_writes_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SHIFT) || (op == OP_MOVE);
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return op_writes_alu(op) || (op == OP_LOADC);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 4x16 register file: two combinational read ports, one synchronous write port.
// Optional debug read port when ALU_ISSUE_REGDUMP_EN is defined.
module alu_issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [REG_AW-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
`ifdef ALU_ISSUE_REGDUMP_EN
  ,
  input  logic [REG_AW-1:0] i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_data
`endif
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (i_we) regs_d[i_waddr] = i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign o_rdata1 = regs_q[i_raddr1];
  assign o_rdata2 = regs_q[i_raddr2];

`ifdef ALU_ISSUE_REGDUMP_EN
  assign o_dbg_data = regs_q[i_dbg_sel];
`endif

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer between fetch and the combinational ALU.
// States: IDLE accept instr | EXEC drive ALU, capture result | WB write reg, pulse done.
// ALU_ISSUE_REGDUMP_EN adds i_dbg_sel/o_dbg_data register readback ports.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [15:0] i_instr,
  output logic [3:0]  o_alu_opcode,
  output logic [1:0]  o_alu_extra,
  output logic [15:0] o_alu_data1,
  output logic [15:0] o_alu_data2,
  output logic [7:0]  o_alu_const,
  input  logic [15:0] i_alu_result,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic        o_unsupported
`ifdef ALU_ISSUE_REGDUMP_EN
  ,
  input  logic [1:0]  i_dbg_sel,
  output logic [15:0] o_dbg_data
`endif
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        unsup_q, unsup_d;
  logic        ready_q, ready_d;

  logic [3:0]        opcode;
  logic [1:0]        extra;
  logic [REG_AW-1:0] ra, rb;
  logic [7:0]        cnst;
  logic [REG_AW-1:0] raddr1;
  logic              wb_we;

  assign opcode = instr_q[OPC_HI:OPC_LO];
  assign extra  = instr_q[EXT_HI:EXT_LO];
  assign ra     = instr_q[RA_HI:RA_LO];
  assign rb     = instr_q[RB_HI:RB_LO];
  assign cnst   = instr_q[CONST_HI:CONST_LO];

  // MOVE routes the source through data1 because the ALU passes data1 on MOVE.
  assign raddr1 = (opcode == OP_MOVE) ? rb : ra;
  assign wb_we  = (state_q == ST_WB) && op_writes(opcode);

  alu_issue_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_raddr1 (raddr1),
    .o_rdata1 (o_alu_data1),
    .i_raddr2 (rb),
    .o_rdata2 (o_alu_data2),
    .i_we     (wb_we),
    .i_waddr  (ra),
    .i_wdata  (result_q)
`ifdef ALU_ISSUE_REGDUMP_EN
    ,
    .i_dbg_sel  (i_dbg_sel),
    .o_dbg_data (o_dbg_data)
`endif
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    unsup_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_instr_valid && ready_q) begin
          instr_d = i_instr;
          ready_d = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        done_d  = 1'b1;
        state_d = ST_WB;
        if (op_writes_alu(opcode)) begin
          result_d = i_alu_result;
        end else if (opcode == OP_LOADC) begin
          result_d = {8'h00, cnst};
        end else begin
          result_d = 16'h0000;
          unsup_d  = 1'b1;
        end
      end
      ST_WB: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= 16'h0000;
      result_q <= 16'h0000;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      unsup_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      unsup_q  <= unsup_d;
    end
  end

  assign o_instr_ready = ready_q;
  assign o_done        = done_q;
  assign o_unsupported = unsup_q;
  assign o_result      = result_q;
  assign o_alu_opcode  = opcode;
  assign o_alu_extra   = extra;
  assign o_alu_const   = cnst;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU closing the loop.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic [15:0] i_instr;
  logic [3:0]  o_alu_opcode;
  logic [1:0]  o_alu_extra;
  logic [15:0] o_alu_data1;
  logic [15:0] o_alu_data2;
  logic [7:0]  o_alu_const;
  logic [15:0] i_alu_result;
  logic        o_done;
  logic [15:0] o_result;
  logic        o_unsupported;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_res;

  always #5 i_clk = ~i_clk;

  alu_issue #(.NUM_REGS(4)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr       (i_instr),
    .o_alu_opcode  (o_alu_opcode),
    .o_alu_extra   (o_alu_extra),
    .o_alu_data1   (o_alu_data1),
    .o_alu_data2   (o_alu_data2),
    .o_alu_const   (o_alu_const),
    .i_alu_result  (i_alu_result),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_unsupported (o_unsupported)
  );

  // Reference ALU: extra[0] selects the constant as operand 2, extra[1] shifts left.
  logic [15:0] alu_op2;
  always_comb begin
    alu_op2 = o_alu_extra[0] ? {8'h00, o_alu_const} : o_alu_data2;
    case (o_alu_opcode)
      OP_ADD:   i_alu_result = o_alu_data1 + alu_op2;
      OP_SUB:   i_alu_result = o_alu_data1 - alu_op2;
      OP_AND:   i_alu_result = o_alu_data1 & alu_op2;
      OP_OR:    i_alu_result = o_alu_data1 | alu_op2;
      OP_SHIFT: i_alu_result = o_alu_extra[1] ? (o_alu_data1 << alu_op2[3:0])
                                              : (o_alu_data1 >> alu_op2[3:0]);
      OP_MOVE:  i_alu_result = o_alu_data1;
      default:  i_alu_result = 16'hDEAD;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] ex,
                                     input logic [1:0] ra, input logic [7:0] c8);
    return {op, ex, ra, c8};
  endfunction

  task automatic issue(input logic [15:0] ins);
    int n = 0;
    while (!o_instr_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_wait", {15'd0, o_instr_ready}, 16'd1);
    i_instr_valid = 1'b1;
    i_instr       = ins;
    @(posedge i_clk);
    #1;
    i_instr_valid = 1'b0;
    i_instr       = 16'hFFFF;
  endtask

  // Issue one instruction and check EXEC (N+1), WB (N+2) and ready again at N+3.
  task automatic run(input string tag, input logic [15:0] ins,
                     input logic [15:0] exp_d1, input logic [15:0] exp_d2,
                     input logic [15:0] exp_res, input logic exp_uns);
    issue(ins);
    @(negedge i_clk);
    check({tag, "_exec_ready"}, {15'd0, o_instr_ready}, 16'd0);
    check({tag, "_exec_done"}, {15'd0, o_done}, 16'd0);
    check({tag, "_opcode"}, {12'd0, o_alu_opcode}, {12'd0, ins[15:12]});
    check({tag, "_extra"}, {14'd0, o_alu_extra}, {14'd0, ins[11:10]});
    check({tag, "_const"}, {8'd0, o_alu_const}, {8'd0, ins[7:0]});
    check({tag, "_data1"}, o_alu_data1, exp_d1);
    check({tag, "_data2"}, o_alu_data2, exp_d2);
    check({tag, "_held_result"}, o_result, prev_res);
    @(negedge i_clk);
    check({tag, "_done"}, {15'd0, o_done}, 16'd1);
    check({tag, "_unsup"}, {15'd0, o_unsupported}, {15'd0, exp_uns});
    check({tag, "_result"}, o_result, exp_res);
    check({tag, "_wb_ready"}, {15'd0, o_instr_ready}, 16'd0);
    @(negedge i_clk);
    check({tag, "_post_done"}, {15'd0, o_done}, 16'd0);
    check({tag, "_post_unsup"}, {15'd0, o_unsupported}, 16'd0);
    check({tag, "_post_ready"}, {15'd0, o_instr_ready}, 16'd1);
    prev_res = exp_res;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset       = 1'b1;
    i_instr_valid = 1'b0;
    i_instr       = 16'h0000;
    prev_res      = 16'h0000;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_ready", {15'd0, o_instr_ready}, 16'd1);
    check("rst_done", {15'd0, o_done}, 16'd0);
    check("rst_unsup", {15'd0, o_unsupported}, 16'd0);
    check("rst_result", o_result, 16'h0000);
    check("rst_opcode", {12'd0, o_alu_opcode}, 16'h0000);
    check("rst_const", {8'd0, o_alu_const}, 16'h0000);
    check("rst_data1", o_alu_data1, 16'h0000);
    check("rst_data2", o_alu_data2, 16'h0000);

    run("loadc_r1_a5", mk(OP_LOADC, 2'b00, 2'd1, 8'hA5), 16'h0000, 16'h0000, 16'h00A5, 1'b0);
    run("add_r1_r1",   mk(OP_ADD,   2'b00, 2'd1, 8'h40), 16'h00A5, 16'h00A5, 16'h014A, 1'b0);
    run("loadc_r0_10", mk(OP_LOADC, 2'b00, 2'd0, 8'h10), 16'h0000, 16'h0000, 16'h0010, 1'b0);
    run("loadc_r1_03", mk(OP_LOADC, 2'b00, 2'd1, 8'h03), 16'h014A, 16'h0010, 16'h0003, 1'b0);
    run("add_r0_r1",   mk(OP_ADD,   2'b00, 2'd0, 8'h40), 16'h0010, 16'h0003, 16'h0013, 1'b0);
    run("loadc_r0_10b",mk(OP_LOADC, 2'b00, 2'd0, 8'h10), 16'h0013, 16'h0013, 16'h0010, 1'b0);
    run("sub_wrap",    mk(OP_SUB,   2'b01, 2'd0, 8'h20), 16'h0010, 16'h0010, 16'hFFF0, 1'b0);
    run("shift_r1",    mk(OP_SHIFT, 2'b11, 2'd1, 8'h04), 16'h0003, 16'hFFF0, 16'h0030, 1'b0);
    run("move_r2_r1",  mk(OP_MOVE,  2'b00, 2'd2, 8'h40), 16'h0030, 16'h0030, 16'h0030, 1'b0);
    run("add_r2_r2",   mk(OP_ADD,   2'b00, 2'd2, 8'h80), 16'h0030, 16'h0030, 16'h0060, 1'b0);
    run("jump",        mk(OP_JUMP,  2'b00, 2'd0, 8'h00), 16'hFFF0, 16'hFFF0, 16'h0000, 1'b1);
    run("add_r0_r0",   mk(OP_ADD,   2'b00, 2'd0, 8'h00), 16'hFFF0, 16'hFFF0, 16'hFFE0, 1'b0);

    // Reset during EXEC of an ADD: no retire, registers cleared.
    issue(mk(OP_ADD, 2'b00, 2'd1, 8'h80));
    @(negedge i_clk);
    check("midrst_exec_data1", o_alu_data1, 16'h0030);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("midrst_done", {15'd0, o_done}, 16'd0);
    check("midrst_ready", {15'd0, o_instr_ready}, 16'd1);
    check("midrst_result", o_result, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("midrst_no_done", {15'd0, o_done}, 16'd0);
    end
    prev_res = 16'h0000;
    run("post_rst_r1_r2", mk(OP_ADD, 2'b00, 2'd1, 8'h80), 16'h0000, 16'h0000, 16'h0000, 1'b0);
    run("post_rst_r0_r3", mk(OP_ADD, 2'b00, 2'd0, 8'hC0), 16'h0000, 16'h0000, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
